// File: rtl/bus_mem_responder.sv
// bus_mem_responder: system-bus responder backed by a byte-lane RAM.
// Acks each selected request with one fc_bus pulse after WAIT_STATES.
//
// Ports:
//   clk           clock
//   rst           asynchronous active-high reset
//   addr_bus      byte address from the initiator
//   data_bus      write data in; read data out only while acking a read
//   rd_bus        read request level, held until fc_bus is seen
//   wr_bus        write request level, held until fc_bus is seen
//   data_mask_bus byte-lane enables, bit i covers data_bus[8i+7:8i]
//   fc_bus        function-complete pulse, one cycle per transaction
//
// Optional build macro: BUS_MEM_WRPROT_EN
//   When defined, writes into the lowest 2^WRPROT_LOG2 bytes of the
//   window are acked with normal timing but leave the RAM untouched.

module bus_mem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
   parameter int          SIZE_LOG2   = 12,
   parameter int          WAIT_STATES = 2,
   parameter int          WRPROT_LOG2 = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr_bus,
   inout  wire  [31:0] data_bus,
   input  logic        rd_bus,
   input  logic        wr_bus,
   input  logic [3:0]  data_mask_bus,
   output logic        fc_bus
);

   localparam int IW    = SIZE_LOG2 - 2;
   localparam int DEPTH = 1 << IW;
   localparam logic [3:0] WS = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACK,
      S_REL
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [3:0]    cnt;
   logic [3:0]    cnt_nx;
   logic [IW-1:0] idx_q;
   logic [IW-1:0] idx_cur;
   logic          is_rd_q;
   logic          rd_cur;
   logic [31:0]   rdata;
   logic          sel;
   logic          req;
   logic          capture;
   logic          enter_ack;
   logic          prot;
   logic          wr_en;
   logic          unused_ok;

   logic [31:0]   mem [DEPTH];

   assign sel = (addr_bus[31:SIZE_LOG2] ==
                 BASE_ADDR[31:SIZE_LOG2]);
   assign req = (rd_bus | wr_bus) & sel;

   // With zero wait states the ACK entry coincides with capture,
   // so the live bus index/direction must be used on that edge.
   assign idx_cur = capture ? addr_bus[SIZE_LOG2-1:2] : idx_q;
   assign rd_cur  = capture ? rd_bus : is_rd_q;

`ifdef BUS_MEM_WRPROT_EN
   localparam logic [SIZE_LOG2:0] PROT_LIM =
      {{SIZE_LOG2{1'b0}}, 1'b1} << WRPROT_LOG2;

   // Base is window-aligned, so the byte offset is the low
   // address bits rebuilt from the word index.
   assign prot = ({1'b0, idx_cur, 2'b00} < PROT_LIM);
`else
   assign prot = 1'b0;
`endif

   assign wr_en = enter_ack & ~rd_cur & ~prot & ~rst;

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      capture   = 1'b0;
      enter_ack = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (req) begin
               capture = 1'b1;
               cnt_nx  = WS;
               if (WAIT_STATES == 0) begin
                  state_nx  = S_ACK;
                  enter_ack = 1'b1;
               end else begin
                  state_nx = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_nx = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_nx  = S_ACK;
               enter_ack = 1'b1;
            end
         end
         S_ACK: begin
            state_nx = S_REL;
         end
         S_REL: begin
            // Wait for the initiator to drop its request so a
            // held level is not served a second time.
            if (!rd_bus && !wr_bus) begin
               state_nx = S_IDLE;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         idx_q   <= '0;
         is_rd_q <= 1'b0;
         rdata   <= 32'h0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (capture) begin
            idx_q   <= addr_bus[SIZE_LOG2-1:2];
            is_rd_q <= rd_bus;
         end
         if (enter_ack && rd_cur) begin
            rdata <= mem[idx_cur];
         end
      end
   end

   // RAM has no reset: contents survive rst.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (data_mask_bus[b]) begin
               mem[idx_cur][8*b +: 8] <= data_bus[8*b +: 8];
            end
         end
      end
   end

   assign fc_bus   = (state == S_ACK);
   assign data_bus = (state == S_ACK && is_rd_q) ? rdata : 32'bz;

   assign unused_ok = ^{addr_bus[1:0], (WRPROT_LOG2 > SIZE_LOG2)};

endmodule

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
- Bus-side responder (slave) for the CPU's system bus: decodes addr_bus against a base/size window and serves rd_bus/wr_bus requests from an internal byte-lane-writable 32-bit word RAM.
- Completes every transaction with a one-cycle fc_bus pulse after a programmable number of wait states.
- Sits on the shared bus beside other responders; fc_bus outputs are OR-combined and data_bus is tri-stated when not driving.

Parameters:
BASE_ADDR, 32'h40000000, byte base address of window; must be aligned to 2^SIZE_LOG2
SIZE_LOG2, 12, window size in bytes = 2^SIZE_LOG2; RAM depth = 2^(SIZE_LOG2-2) words; legal range 3..20
WAIT_STATES, 2, extra cycles between request capture and ack; 0..15
WRPROT_LOG2, 10, protected low region in bytes = 2^WRPROT_LOG2; used only with BUS_MEM_WRPROT_EN; must be <= SIZE_LOG2

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
addr_bus  input  32  byte address from initiator
data_bus  inout  32  write data in; read data out during ACK only, else high-Z
rd_bus  input  1  read request level, held until initiator sees fc_bus
wr_bus  input  1  write request level, held until initiator sees fc_bus
data_mask_bus  input  4  byte-lane enables; bit i = data_bus[8i+7:8i]
fc_bus  output  1  function complete, one-cycle pulse; 0 when not selected

Behaviour:
- Reset (async, any state): state=IDLE, fc_bus=0, data_bus high-Z, wait counter=0, latched regs cleared; RAM contents untouched.
- sel = (addr_bus[31:SIZE_LOG2] == BASE_ADDR[31:SIZE_LOG2]). Word index = addr[SIZE_LOG2-1:2]; addr[1:0] ignored; no lane shifting (data is lane-aligned by initiator).
- FSM: IDLE, WAIT, ACK, RELEASE.
- IDLE: on (rd_bus|wr_bus)&sel latch word index, is_rd=rd_bus, counter=WAIT_STATES; go WAIT if WAIT_STATES>0 else ACK. Unselected requests ignored.
- WAIT: counter decrements each cycle; when counter==1 go ACK.
- Transition into ACK: read -> RAM word registered into rdata; write -> data_bus sampled, lanes with mask=1 written. Latency: request seen at edge 0, fc_bus high during cycle WAIT_STATES+1.
- ACK: fc_bus=1 exactly one cycle; data_bus=rdata if is_rd. Then RELEASE.
- RELEASE: fc_bus=0; return to IDLE once rd_bus=0 and wr_bus=0 (same-cycle check); prevents double-serving a held request.
- rd_bus and wr_bus both high: treated as read, no write.
- Write with mask 4'b0000: no bytes changed, still acked.
- Request dropped before ack: transaction still completes internally (write applied), fc_bus still pulses once.
- addr_bus change after capture: ignored; latched index used.
- Read of never-written word: X in sim; no init required.

Optional Feature:
BUS_MEM_WRPROT_EN: defined -> writes whose byte offset (addr - BASE_ADDR) < 2^WRPROT_LOG2 are acked normally with the same latency but RAM is not modified; reads unaffected. Undefined -> whole window writable, WRPROT_LOG2 unused.

Test Plan:
- WAIT_STATES=2: write 0xDEADBEEF mask 1111 at 0x40000010, then read 0x40000010 -> fc_bus pulses 3 cycles after each capture, read returns 0xDEADBEEF, data_bus high-Z outside ACK.
- Byte lanes: write 0x11223344 mask 1111, then 0x000000AA mask 0001 and 0x0000BB00 mask 0010 at 0x40000020 -> read returns 0x1122BBAA.
- Decode: read 0x50000000 (outside window) -> fc_bus stays 0 for 20 cycles, data_bus high-Z; window at 0x40000FFC serves, 0x40001000 ignored.
- Held request: rd_bus held 5 cycles past fc -> exactly one fc pulse; new read issued after rd_bus low for 1 cycle is served.
- Reset mid-WAIT: rst pulse during counter=1 -> fc_bus 0, data_bus high-Z immediately; previously written 0xCAFEF00D at 0x40000040 still reads back.
- BUS_MEM_WRPROT_EN, WRPROT_LOG2=10: write 0x12345678 to 0x40000100 -> acked, readback unchanged; write to 0x40000400 -> readback 0x12345678.
